and_gate: RTL and testbench



---
 rtl/and_gate_pkg.sv | 12 +
 rtl/and_gate.sv | 103 ++++++++++
 tb/tb_and_gate.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/and_gate_pkg.sv
// ----------------------------------------------------------------------------
// and_gate_pkg
// Purpose : default geometry for the and_gate primitive. The block keeps
//           WIDTH and CNT_W as its own parameters; these are only the values
//           used when an instance does not override them.
// ----------------------------------------------------------------------------
package and_gate_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 8;

endpackage : and_gate_pkg

// File: rtl/and_gate.sv
// ----------------------------------------------------------------------------
// and_gate
// Purpose : bitwise AND of two operand vectors. It has a zero-latency
//           combinational result, a registered and valid-qualified copy of
//           that result, and a saturating count of accepted all-ones results.
//
// Ports
//   clk        in   1      rising-edge clock for the registered outputs
//   rst        in   1      synchronous, active-high reset
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   in_valid   in   1      qualifies A/B for the registered path
//   C          out  WIDTH  combinational A & B (never reset)
//   all_ones   out  1      combinational reduction-AND of C
//   C_q        out  WIDTH  registered result
//   out_valid  out  1      one-cycle pulse: C_q holds a freshly accepted result
//   match_cnt  out  CNT_W  saturating count of accepted all-ones results
// ----------------------------------------------------------------------------
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH-1:0] C,
    output logic             all_ones,
    output logic [WIDTH-1:0] C_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Increment that sticks at the maximum code instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + CNT_W'(1'b1);
        end
    endfunction

    logic [WIDTH-1:0] c_s;
    logic             all_ones_s;

    logic [WIDTH-1:0] c_q_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] match_cnt_r;

    logic [WIDTH-1:0] c_q_nxt_s;
    logic             out_valid_nxt_s;
    logic [CNT_W-1:0] match_cnt_nxt_s;

    // The gate itself: no clock or reset involvement, valid even during reset.
    assign c_s        = A & B;
    assign all_ones_s = &c_s;

    assign C         = c_s;
    assign all_ones  = all_ones_s;
    assign C_q       = c_q_r;
    assign out_valid = out_valid_r;
    assign match_cnt = match_cnt_r;

    // Next-state for the registered path: capture on in_valid, otherwise hold
    // the data and drop the valid pulse.
    always_comb begin
        c_q_nxt_s       = c_q_r;
        out_valid_nxt_s = 1'b0;
        match_cnt_nxt_s = match_cnt_r;
        if (in_valid) begin
            c_q_nxt_s       = c_s;
            out_valid_nxt_s = 1'b1;
            if (all_ones_s) begin
                match_cnt_nxt_s = sat_inc(match_cnt_r);
            end else begin
                match_cnt_nxt_s = match_cnt_r;
            end
        end else begin
            c_q_nxt_s       = c_q_r;
            out_valid_nxt_s = 1'b0;
            match_cnt_nxt_s = match_cnt_r;
        end
    end

    // Registered path; reset takes priority over a simultaneous capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            match_cnt_r <= {CNT_W{1'b0}};
        end else begin
            c_q_r       <= c_q_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            match_cnt_r <= match_cnt_nxt_s;
        end
    end

endmodule : and_gate

// File: tb/tb_and_gate.sv
// ----------------------------------------------------------------------------
// tb_and_gate
// Three instances: a 1-bit gate for the truth table, a 4-bit gate with an
// 8-bit counter for capture/reset/counting, and a 4-bit gate with a 2-bit
// counter for saturation and mid-stream reset. Stimulus pushes expected
// registered results into per-instance queues; monitors pop on out_valid.
// ----------------------------------------------------------------------------
module tb_and_gate;

    typedef struct packed {
        logic [3:0] c;
        logic [7:0] cnt;
    } exp_t;

    logic clk;

    // 1-bit instance
    logic       rst1, a1, b1, v1;
    logic       c1, all1, cq1, ov1;
    logic [7:0] cnt1;

    // 4-bit, CNT_W=8 instance
    logic       rst4, v4;
    logic [3:0] a4, b4, c4, cq4;
    logic       all4, ov4;
    logic [7:0] cnt4;

    // 4-bit, CNT_W=2 instance
    logic       rst_s, v_s;
    logic [3:0] a_s, b_s, c_s, cq_s;
    logic       all_s, ov_s;
    logic [1:0] cnt_s;

    int total = 0;
    int bad   = 0;

    exp_t q4[$];
    exp_t qs[$];

    and_gate #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst1), .A(a1), .B(b1), .in_valid(v1),
        .C(c1), .all_ones(all1), .C_q(cq1), .out_valid(ov1), .match_cnt(cnt1)
    );

    and_gate #(.WIDTH(4), .CNT_W(8)) u_w4 (
        .clk(clk), .rst(rst4), .A(a4), .B(b4), .in_valid(v4),
        .C(c4), .all_ones(all4), .C_q(cq4), .out_valid(ov4), .match_cnt(cnt4)
    );

    and_gate #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst_s), .A(a_s), .B(b_s), .in_valid(v_s),
        .C(c_s), .all_ones(all_s), .C_q(cq_s), .out_valid(ov_s), .match_cnt(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // sel 0: 4-bit/8-bit-counter instance, sel 1: saturation instance.
    // exp_c / exp_cnt are hand-computed values for this vector.
    task automatic drive(input int sel, input logic r, input logic [3:0] a, input logic [3:0] b,
                         input logic v, input logic [3:0] exp_c, input logic [7:0] exp_cnt);
        exp_t e;
        e.c   = exp_c;
        e.cnt = exp_cnt;
        if (sel == 0) begin
            rst4 = r; a4 = a; b4 = b; v4 = v;
            if (v && !r) q4.push_back(e);
            #1;
            check("comb_c_w4", {28'd0, c4}, {28'd0, exp_c});
            check("comb_all_w4", {31'd0, all4}, {31'd0, (exp_c == 4'hF)});
        end else begin
            rst_s = r; a_s = a; b_s = b; v_s = v;
            if (v && !r) qs.push_back(e);
            #1;
            check("comb_c_sat", {28'd0, c_s}, {28'd0, exp_c});
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor for the 4-bit/8-bit instance.
    always @(negedge clk) begin
        if (ov4 === 1'b1) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid_w4: got out_valid=1 expected no output");
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("cq_w4", {28'd0, cq4}, {28'd0, e.c});
                check("cnt_w4", {24'd0, cnt4}, {24'd0, e.cnt});
            end
        end
    end

    // Monitor for the saturation instance.
    always @(negedge clk) begin
        if (ov_s === 1'b1) begin
            if (qs.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid_sat: got out_valid=1 expected no output");
            end else begin
                exp_t e;
                e = qs.pop_front();
                check("cq_sat", {28'd0, cq_s}, {28'd0, e.c});
                check("cnt_sat", {30'd0, cnt_s}, {24'd0, e.cnt});
            end
        end
    end

    initial begin
        rst1 = 1'b1; a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
        rst4 = 1'b1; a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
        rst_s = 1'b1; a_s = 4'h0; b_s = 4'h0; v_s = 1'b0;

        // Truth table on the 1-bit gate, each pair held 10 ns.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = i[1:0];
            a1 = ab[1];
            b1 = ab[0];
            #5;
            check("tt_c", {31'd0, c1}, {31'd0, (i == 3)});
            check("tt_all_ones", {31'd0, all1}, {31'd0, (i == 3)});
            #5;
        end

        // Reset held with in_valid=1 and all-ones operands across several edges.
        #1;
        check("rst_c", {28'd0, c4}, 32'h0000_000F);
        check("rst_cq", {28'd0, cq4}, 32'd0);
        check("rst_valid", {31'd0, ov4}, 32'd0);
        check("rst_cnt", {24'd0, cnt4}, 32'd0);
        check("rst_cnt_sat", {30'd0, cnt_s}, 32'd0);
        @(posedge clk);
        #2;

        // Registered capture, then an idle edge.
        drive(0, 1'b0, 4'b1100, 4'b1010, 1'b1, 4'b1000, 8'd0);
        drive(0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'd0);
        check("idle_valid", {31'd0, ov4}, 32'd0);
        check("idle_cq_hold", {28'd0, cq4}, 32'h0000_0008);

        // Match counting: three all-ones, two not.
        drive(0, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd1);
        drive(0, 1'b0, 4'hF, 4'hE, 1'b1, 4'hE, 8'd1);
        drive(0, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd2);
        drive(0, 1'b0, 4'h5, 4'hA, 1'b1, 4'h0, 8'd2);
        drive(0, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd3);
        drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 8'd3);
        check("final_cnt", {24'd0, cnt4}, 32'd3);

        // Saturation with a 2-bit counter.
        drive(1, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd1);
        drive(1, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd2);
        drive(1, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd3);
        drive(1, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd3);
        drive(1, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd3);

        // Mid-stream reset once the count reaches 2, with in_valid also high.
        drive(1, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 8'd0);
        drive(1, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd1);
        drive(1, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd2);
        drive(1, 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 8'd0);
        check("mid_rst_cnt", {30'd0, cnt_s}, 32'd0);
        check("mid_rst_cq", {28'd0, cq_s}, 32'd0);
        check("mid_rst_valid", {31'd0, ov_s}, 32'd0);
        drive(1, 1'b0, 4'hF, 4'hF, 1'b1, 4'hF, 8'd1);
        drive(1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 8'd1);
        check("restart_cnt", {30'd0, cnt_s}, 32'd1);

        // Let the monitors drain, then every expected result must have appeared.
        repeat (2) @(posedge clk);
        #2;
        check("q_w4_drained", q4.size(), 32'd0);
        check("q_sat_drained", qs.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_and_gate
